// File: rtl/v68k_alu_pkg.sv
// Shared definitions for the 68k ALU sequencer: op codes, operand size and sequencer states.
package v68k_alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    typedef enum logic {
        SZ_WORD = 1'b0,
        SZ_LONG = 1'b1
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } seq_state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= ALU_XOR;
    endfunction

endpackage

// File: rtl/Alu.sv
// One slice of the 68k ALU: add/sub with carry-in, logic ops; illegal codes pass A through.
module Alu
    import v68k_alu_pkg::*;
#(
    parameter int bits = 16
) (
    input  logic [bits-1:0] a,
    input  logic [bits-1:0] b,
    input  logic            x,
    input  logic [2:0]      op,
    output logic [bits-1:0] o,
    output logic            c
);

    logic [bits:0] sum;
    logic [bits:0] dif;

    // The extra top bit of the difference is the borrow out.
    assign sum = {1'b0, a} + {1'b0, b} + {{bits{1'b0}}, x};
    assign dif = {1'b0, a} - {1'b0, b} - {{bits{1'b0}}, x};

    always_comb begin
        o = a;
        c = 1'b0;
        case (op)
            ALU_ADD: {c, o} = sum;
            ALU_SUB: {c, o} = dif;
            ALU_AND: o = a & b;
            ALU_OR:  o = a | b;
            ALU_XOR: o = a ^ b;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_long_sequencer.sv
// Runs word/long ADD/SUB/AND/OR/XOR through one 16-bit Alu slice, low half then high half,
// and produces 68k X/N/Z/V/C including sticky Z for extend-mode ops.
module alu_long_sequencer
    import v68k_alu_pkg::*;
#(
    parameter int WORD_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic                   req_long,
    input  logic                   req_ext,
    input  logic [2*WORD_BITS-1:0] req_a,
    input  logic [2*WORD_BITS-1:0] req_b,
    input  logic                   x_in,
    input  logic                   z_in,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2*WORD_BITS-1:0] rsp_result,
    output logic                   rsp_x,
    output logic                   rsp_n,
    output logic                   rsp_z,
    output logic                   rsp_v,
    output logic                   rsp_c,
    output logic                   rsp_err
);

    localparam int LW = 2 * WORD_BITS;

    seq_state_e           state;
    logic [2:0]           op_q;
    size_e                size_q;
    logic                 ext_q, x_q, z_q;
    logic [LW-1:0]        a_q, b_q;
    logic [WORD_BITS-1:0] lo_o_q;
    logic                 lo_c_q;

    logic [WORD_BITS-1:0] alu_a, alu_b, alu_o;
    logic                 alu_x, alu_c;
    logic                 fin;
    logic [LW-1:0]        fin_result;
    logic                 fin_zero;
    logic [4:0]           fin_cc;

    // Returns {X, N, Z, V, C}; V is derived from the final slice's sign bits.
    function automatic logic [4:0] cc_flags(input logic [2:0] op, input logic ext,
                                            input logic xl, input logic zl,
                                            input logic as, input logic bs, input logic rs,
                                            input logic zero, input logic c);
        logic xx, vv, cc;
        xx = xl;
        vv = 1'b0;
        cc = 1'b0;
        if (op == ALU_ADD) begin
            xx = c;
            cc = c;
            vv = (as == bs) && (rs != as);
        end else if (op == ALU_SUB) begin
            xx = c;
            cc = c;
            vv = (as != bs) && (rs != as);
        end
        return {xx, rs, ext ? (zl & zero) : zero, vv, cc};
    endfunction

    always_comb begin
        if (state == S_HIGH) begin
            alu_a = a_q[LW-1:WORD_BITS];
            alu_b = b_q[LW-1:WORD_BITS];
            alu_x = lo_c_q;
        end else begin
            alu_a = a_q[WORD_BITS-1:0];
            alu_b = b_q[WORD_BITS-1:0];
            alu_x = ext_q & x_q;
        end
    end

    Alu #(.bits(WORD_BITS)) u_alu (
        .a  (alu_a),
        .b  (alu_b),
        .x  (alu_x),
        .op (op_q),
        .o  (alu_o),
        .c  (alu_c)
    );

    // Final slice: word keeps the upper destination half, long tests zero over both slices.
    assign fin        = (state == S_HIGH) || (state == S_LOW && size_q == SZ_WORD);
    assign fin_result = (state == S_HIGH) ? {alu_o, lo_o_q} : {a_q[LW-1:WORD_BITS], alu_o};
    assign fin_zero   = (state == S_HIGH) ? (fin_result == '0) : (alu_o == '0);
    assign fin_cc     = cc_flags(op_q, ext_q, x_q, z_q, alu_a[WORD_BITS-1], alu_b[WORD_BITS-1],
                                 alu_o[WORD_BITS-1], fin_zero, alu_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_x      <= 1'b0;
            rsp_n      <= 1'b0;
            rsp_z      <= 1'b0;
            rsp_v      <= 1'b0;
            rsp_c      <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state     <= S_LOW;
                        req_ready <= 1'b0;
                    end
                end
                S_LOW, S_HIGH: begin
                    if (fin) begin
                        state      <= S_DONE;
                        rsp_valid  <= 1'b1;
                        rsp_result <= fin_result;
                        {rsp_x, rsp_n, rsp_z, rsp_v, rsp_c} <= fin_cc;
                        rsp_err    <= !op_legal(op_q);
                    end else begin
                        state <= S_HIGH;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Request and low-slice holding registers carry data only, so they are not reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_valid) begin
            op_q   <= req_op;
            size_q <= size_e'(req_long);
            ext_q  <= req_ext;
            x_q    <= x_in;
            z_q    <= z_in;
            a_q    <= req_a;
            b_q    <= req_b;
        end
        if (state == S_LOW) begin
            lo_o_q <= alu_o;
            lo_c_q <= alu_c;
        end
    end

endmodule

// File: tb/tb_alu_long_sequencer.sv
// Scoreboard bench for alu_long_sequencer: directed vectors with hand-computed results.
module tb_alu_long_sequencer;

    typedef struct packed {
        logic [31:0] res;
        logic        x, n, z, v, c, err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic        req_long = 1'b0;
    logic        req_ext = 1'b0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        x_in = 1'b0;
    logic        z_in = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic        rsp_x, rsp_n, rsp_z, rsp_v, rsp_c, rsp_err;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    alu_long_sequencer #(.WORD_BITS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_long   (req_long),
        .req_ext    (req_ext),
        .req_a      (req_a),
        .req_b      (req_b),
        .x_in       (x_in),
        .z_in       (z_in),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_x      (rsp_x),
        .rsp_n      (rsp_n),
        .rsp_z      (rsp_z),
        .rsp_v      (rsp_v),
        .rsp_c      (rsp_c),
        .rsp_err    (rsp_err)
    );

    function automatic exp_t mk(input logic [31:0] res, input logic x, input logic n,
                                input logic z, input logic v, input logic c, input logic err);
        exp_t e;
        e = '{res: res, x: x, n: n, z: z, v: v, c: c, err: err};
        return e;
    endfunction

    function automatic exp_t dut_rsp();
        return mk(rsp_result, rsp_x, rsp_n, rsp_z, rsp_v, rsp_c, rsp_err);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted response is popped and compared.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got result %h with empty scoreboard", rsp_result);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (dut_rsp() !== e) begin
                    errors++;
                    $display("FAIL rsp: got res=%h xnzvc=%b%b%b%b%b err=%b expected res=%h xnzvc=%b%b%b%b%b err=%b",
                             rsp_result, rsp_x, rsp_n, rsp_z, rsp_v, rsp_c, rsp_err,
                             e.res, e.x, e.n, e.z, e.v, e.c, e.err);
                end
            end
        end
    end

    task automatic wait_idle(output bit ok);
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        ok = req_ready;
        if (!ok) chk("req_ready_timeout", {63'd0, req_ready}, 64'd1);
    endtask

    // Issues one request and checks the accept-to-valid latency; the monitor checks the data.
    task automatic issue(input string name, input logic [2:0] op, input logic lng, input logic ext,
                         input logic [31:0] a, input logic [31:0] b, input logic xi,
                         input logic zi, input exp_t e, input int lat, input bit track);
        bit ok;
        int n;
        wait_idle(ok);
        if (!ok) return;
        if (track) sbq.push_back(e);
        req_valid = 1'b1; req_op = op; req_long = lng; req_ext = ext;
        req_a = a; req_b = b; x_in = xi; z_in = zi;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_a = 32'hDEAD_BEEF; req_b = 32'h5A5A_A5A5;
        x_in = ~xi; z_in = ~zi; req_op = 3'd1;
        if (lat == 0) return;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 10);
        chk({name, "_latency"}, 64'(n), 64'(lat));
    endtask

    initial begin
        bit ok;
        #1;
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_outputs", {26'd0, rsp_result, rsp_x, rsp_n, rsp_z, rsp_v, rsp_c, rsp_err}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_req_ready", {63'd0, req_ready}, 64'd1);

        issue("word_add_ovf", 3'd0, 1'b0, 1'b0, 32'h1234_7FFF, 32'h0000_0001, 1'b0, 1'b0,
              mk(32'h1234_8000, 0, 1, 0, 1, 0, 0), 2, 1'b1);
        issue("long_add_chain", 3'd0, 1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0,
              mk(32'h0001_0000, 0, 0, 0, 0, 0, 0), 3, 1'b1);
        issue("long_sub_borrow", 3'd1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0,
              mk(32'hFFFF_FFFF, 1, 1, 0, 0, 1, 0), 3, 1'b1);
        issue("long_addx_z1", 3'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1,
              mk(32'h0000_0000, 1, 0, 1, 0, 1, 0), 3, 1'b1);
        issue("long_addx_z0", 3'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0,
              mk(32'h0000_0000, 1, 0, 0, 0, 1, 0), 3, 1'b1);
        issue("long_addx_nz", 3'd0, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1,
              mk(32'h0000_0001, 0, 0, 0, 0, 0, 0), 3, 1'b1);
        issue("word_sub_keep_hi", 3'd1, 1'b0, 1'b0, 32'hABCD_0005, 32'hFFFF_0007, 1'b0, 1'b0,
              mk(32'hABCD_FFFE, 1, 1, 0, 0, 1, 0), 2, 1'b1);
        issue("word_sub_ovf", 3'd1, 1'b0, 1'b0, 32'h0000_8000, 32'h0000_0001, 1'b1, 1'b0,
              mk(32'h0000_7FFF, 0, 0, 0, 1, 0, 0), 2, 1'b1);
        issue("word_addx_z", 3'd0, 1'b0, 1'b1, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b1,
              mk(32'h0000_0000, 1, 0, 1, 0, 1, 0), 2, 1'b1);
        issue("long_and_zero", 3'd2, 1'b1, 1'b0, 32'hF0F0_FFFF, 32'h0F0F_0000, 1'b1, 1'b0,
              mk(32'h0000_0000, 1, 0, 1, 0, 0, 0), 3, 1'b1);
        issue("long_or_neg", 3'd3, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0,
              mk(32'h8000_0001, 0, 1, 0, 0, 0, 0), 3, 1'b1);
        issue("word_xor_zero", 3'd4, 1'b0, 1'b0, 32'h5555_AAAA, 32'h1234_AAAA, 1'b1, 1'b0,
              mk(32'h5555_0000, 1, 0, 1, 0, 0, 0), 2, 1'b1);
        issue("long_xor_hi_only", 3'd4, 1'b1, 1'b0, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b0,
              mk(32'h0001_0000, 0, 0, 0, 0, 0, 0), 3, 1'b1);
        issue("word_illegal", 3'd7, 1'b0, 1'b0, 32'h8000_0000, 32'h1111_1111, 1'b1, 1'b0,
              mk(32'h8000_0000, 1, 0, 1, 0, 0, 1), 2, 1'b1);

        // Backpressure with an illegal long op held in DONE.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        issue("long_illegal_bp", 3'd5, 1'b1, 1'b0, 32'hCAFE_0001, 32'h1234_5678, 1'b1, 1'b0,
              mk(32'hCAFE_0001, 1, 1, 0, 0, 0, 1), 3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {26'd0, dut_rsp()}, {26'd0, mk(32'hCAFE_0001, 1, 1, 0, 0, 0, 1)});
            chk("bp_flow", {62'd0, rsp_valid, req_ready}, 64'd2);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", {62'd0, rsp_valid, req_ready}, 64'd1);

        // Reset during the high slice of a long op: the op is dropped.
        issue("rst_mid_op", 3'd0, 1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0,
              mk(32'h0, 0, 0, 0, 0, 0, 0), 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_ready", {63'd0, req_ready}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end

        issue("post_rst_add", 3'd0, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
              mk(32'h8000_0000, 0, 1, 0, 1, 0, 0), 3, 1'b1);

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
